// File: rtl/fu_cdb_arbiter.sv
// FU busy/done tracker and round-robin CDB lane arbiter; grants are combinational, state updates next cycle.
// Optional ARB_PERF_CNT_EN adds saturating perf_denied / perf_grants counters.
module fu_cdb_arbiter #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic [NUM_FU-1:0]      fu_issue,
  input  logic [NUM_FU-1:0]      fu_done,
  output logic [NUM_FU-1:0]      cdb_grant,
  output logic [CDB_W-1:0]       cdb_valid,
  output logic [CDB_W*IDX_W-1:0] cdb_idx,
  output logic [NUM_FU-1:0]      fu_ready,
  output logic                   proto_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_denied,
  output logic [31:0]            perf_grants
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fu_state_e;

  fu_state_e            state_q [NUM_FU];
  fu_state_e            state_d [NUM_FU];
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 proto_err_q, proto_err_d;

  logic                 flush;
  logic [NUM_FU-1:0]    fu_idle;
  logic [NUM_FU-1:0]    req;
  logic [NUM_FU-1:0]    done_err;
  logic [NUM_FU-1:0]    issue_ok;
  logic [NUM_FU-1:0]    issue_err;
  logic [NUM_FU-1:0]    grant;
  logic [CDB_W-1:0]     lane_vld;
  logic [CDB_W*IDX_W-1:0] lane_idx;

  assign flush = reset | squash;

  // Requests are masked during reset/squash so no lane is granted in a flush cycle.
  always_comb begin
    fu_idle  = '0;
    req      = '0;
    done_err = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_idle[i]  = (state_q[i] == ST_IDLE);
      req[i]      = fu_done[i] & ~fu_idle[i] & ~flush;
      done_err[i] = fu_done[i] & fu_idle[i] & ~flush;
    end
  end

  always_comb begin
    logic [IDX_W-1:0] scan;
    logic [IDX_W-1:0] last;
    int               n;
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    scan     = '0;
    last     = rr_ptr_q;
    n        = 0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = IDX_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (req[scan] && (n < CDB_W)) begin
        grant[scan]                  = 1'b1;
        lane_vld[n]                  = 1'b1;
        lane_idx[n*IDX_W +: IDX_W]   = scan;
        last                         = scan;
        n                            = n + 1;
      end
    end
    rr_ptr_d = (n > 0) ? IDX_W'((int'(last) + 1) % NUM_FU) : rr_ptr_q;
  end

  assign cdb_grant = grant;
  assign cdb_valid = lane_vld;
  assign cdb_idx   = lane_idx;
  assign fu_ready  = flush ? '0 : (fu_idle | grant);
  assign issue_ok  = fu_issue & fu_ready;
  assign issue_err = flush ? '0 : (fu_issue & ~fu_ready);

  // A DONE FU that drops fu_done stays DONE; it simply stops requesting.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      state_d[i] = state_q[i];
      if (flush) begin
        state_d[i] = ST_IDLE;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            if (issue_ok[i]) state_d[i] = ST_BUSY;
          end
          ST_BUSY, ST_DONE: begin
            if (grant[i])    state_d[i] = issue_ok[i] ? ST_BUSY : ST_IDLE;
            else if (req[i]) state_d[i] = ST_DONE;
          end
          default: state_d[i] = ST_IDLE;
        endcase
      end
    end
    proto_err_d = proto_err_q | (|issue_err) | (|done_err);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) state_q[i] <= ST_IDLE;
      rr_ptr_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) state_q[i] <= state_d[i];
      rr_ptr_q    <= rr_ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q & ~reset;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_denied_q, perf_denied_d;
  logic [31:0] perf_grants_q, perf_grants_d;
  logic [32:0] grants_sum;

  always_comb begin
    grants_sum    = {1'b0, perf_grants_q} + 33'($countones(grant));
    perf_grants_d = grants_sum[32] ? '1 : grants_sum[31:0];
    perf_denied_d = perf_denied_q;
    if ((|(req & ~grant)) && (perf_denied_q != '1)) perf_denied_d = perf_denied_q + 32'd1;
  end

  // Counters survive squash so they reflect whole-run behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_denied_q <= '0;
      perf_grants_q <= '0;
    end else begin
      perf_denied_q <= perf_denied_d;
      perf_grants_q <= perf_grants_d;
    end
  end

  assign perf_denied = reset ? '0 : perf_denied_q;
  assign perf_grants = reset ? '0 : perf_grants_q;
`endif

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Directed table-driven bench for fu_cdb_arbiter (NUM_FU=8, CDB_W=3) with hand-computed expectations.
module tb_fu_cdb_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       squash;
  logic [7:0] fu_issue;
  logic [7:0] fu_done;
  logic [7:0] cdb_grant;
  logic [2:0] cdb_valid;
  logic [8:0] cdb_idx;
  logic [7:0] fu_ready;
  logic       proto_err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_denied;
  logic [31:0] perf_grants;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fu_cdb_arbiter #(.NUM_FU(8), .CDB_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .fu_issue  (fu_issue),
    .fu_done   (fu_done),
    .cdb_grant (cdb_grant),
    .cdb_valid (cdb_valid),
    .cdb_idx   (cdb_idx),
    .fu_ready  (fu_ready),
    .proto_err (proto_err)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_denied (perf_denied),
    .perf_grants (perf_grants)
`endif
  );

  typedef struct {
    logic       rst;
    logic       sq;
    logic [7:0] iss;
    logic [7:0] dn;
    logic [7:0] grant;
    logic [2:0] vld;
    logic [8:0] idx;
    logic [7:0] rdy;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic [7:0] iss, input logic [7:0] dn,
                     input logic [7:0] g, input logic [2:0] v, input logic [8:0] idx,
                     input logic [7:0] rdy, input logic err);
    vec_t t;
    t.rst = r; t.sq = s; t.iss = iss; t.dn = dn;
    t.grant = g; t.vld = v; t.idx = idx; t.rdy = rdy; t.err = err;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  // Drive, sample mid-cycle, then let the edge commit.
  task automatic run_vec(input int n, input vec_t t);
    reset = t.rst; squash = t.sq; fu_issue = t.iss; fu_done = t.dn;
    #3;
    chk("cdb_grant", n, 32'(cdb_grant), 32'(t.grant));
    chk("cdb_valid", n, 32'(cdb_valid), 32'(t.vld));
    chk("cdb_idx",   n, 32'(cdb_idx),   32'(t.idx));
    chk("fu_ready",  n, 32'(fu_ready),  32'(t.rdy));
    chk("proto_err", n, 32'(proto_err), 32'(t.err));
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fu_issue = '0; fu_done = '0;

    //   rst sq  issue  done   grant  vld     idx      ready  err
    add(1, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'h00, 0); // 0 reset cycle
    add(1, 0, 8'hFF, 8'hFF, 8'h00, 3'b000, 9'h000, 8'h00, 0); // 1 reset beats issue/done
    add(0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 0); // 2 idle after reset
    add(0, 0, 8'h0F, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 0); // 3 issue FU0..3
    add(0, 0, 8'h00, 8'h0F, 8'h07, 3'b111, 9'h088, 8'hF7, 0); // 4 grant 0,1,2; FU3 waits
    add(0, 0, 8'h00, 8'h08, 8'h08, 3'b001, 9'h003, 8'hFF, 0); // 5 FU3 lane0, rr->4
    add(0, 0, 8'hA3, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 0); // 6 issue 0,1,5,7
    add(0, 0, 8'h20, 8'h20, 8'h20, 3'b001, 9'h005, 8'h7C, 0); // 7 FU5 granted+reissued, rr->6
    add(0, 0, 8'h00, 8'hA3, 8'h83, 3'b111, 9'h047, 8'hDF, 0); // 8 wrap: 7,0,1; FU5 waits, rr->2
    add(0, 0, 8'h04, 8'h20, 8'h20, 3'b001, 9'h005, 8'hFF, 0); // 9 FU5 lane0, FU2 issued, rr->6
    add(0, 0, 8'h04, 8'h04, 8'h04, 3'b001, 9'h002, 8'hFF, 0); // 10 FU2 granted + issue
    add(0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFB, 0); // 11 FU2 busy again
    add(0, 0, 8'h20, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFB, 0); // 12 issue FU5
    add(0, 0, 8'h20, 8'h00, 8'h00, 3'b000, 9'h000, 8'hDB, 0); // 13 issue FU5 while busy
    add(0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'hDB, 1); // 14 proto_err sticky
    add(0, 0, 8'h00, 8'h24, 8'h24, 3'b011, 9'h015, 8'hFF, 1); // 15 rr=3: FU5 lane0, FU2 lane1
    add(0, 0, 8'hF2, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 1); // 16 issue 1,4,5,6,7
    add(0, 0, 8'h10, 8'h10, 8'h10, 3'b001, 9'h004, 8'h1D, 1); // 17 FU4 regrant, rr->5
    add(0, 0, 8'h00, 8'hF2, 8'hE0, 3'b111, 9'h1F5, 8'hED, 1); // 18 grant 5,6,7; 1,4 DONE
    add(0, 1, 8'hFF, 8'h12, 8'h00, 3'b000, 9'h000, 8'h00, 1); // 19 squash cycle
    add(0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 1); // 20 all idle after squash
    add(0, 0, 8'h00, 8'h12, 8'h00, 3'b000, 9'h000, 8'hFF, 1); // 21 done while idle ignored
    add(1, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'h00, 0); // 22 reset clears proto_err
    add(0, 0, 8'h00, 8'h00, 8'h00, 3'b000, 9'h000, 8'hFF, 0); // 23 idle

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
`ifdef ARB_PERF_CNT_EN
      if (i == 4) begin
        chk("perf_denied", i, perf_denied, 32'd1);
        chk("perf_grants", i, perf_grants, 32'd3);
      end
`endif
    end

    // All eight FUs finish together; DONE results drain over three cycles from rr=0.
    begin
      vec_t t;
      t = '{rst:0, sq:0, iss:8'hFF, dn:8'h00, grant:8'h00, vld:3'b000, idx:9'h000, rdy:8'hFF, err:0};
      run_vec(100, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'hFF, grant:8'h07, vld:3'b111, idx:9'h088, rdy:8'h07, err:0};
      run_vec(101, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'hF8, grant:8'h38, vld:3'b111, idx:9'h163, rdy:8'h3F, err:0};
      run_vec(102, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'hC0, grant:8'hC0, vld:3'b011, idx:9'h03E, rdy:8'hFF, err:0};
      run_vec(103, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'h00, grant:8'h00, vld:3'b000, idx:9'h000, rdy:8'hFF, err:0};
      run_vec(104, t);
      // rr wrapped to 0: FU1 and FU0 requesting must land in index order.
      t = '{rst:0, sq:0, iss:8'h03, dn:8'h00, grant:8'h00, vld:3'b000, idx:9'h000, rdy:8'hFF, err:0};
      run_vec(105, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'h03, grant:8'h03, vld:3'b011, idx:9'h008, rdy:8'hFF, err:0};
      run_vec(106, t);
      // fu_done on an idle FU raises proto_err one cycle later.
      t = '{rst:0, sq:0, iss:8'h00, dn:8'h40, grant:8'h00, vld:3'b000, idx:9'h000, rdy:8'hFF, err:0};
      run_vec(107, t);
      t = '{rst:0, sq:0, iss:8'h00, dn:8'h00, grant:8'h00, vld:3'b000, idx:9'h000, rdy:8'hFF, err:1};
      run_vec(108, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_cdb_arbiter.md
Name: fu_cdb_arbiter

Overview:
- Tracks the busy/done state of every functional unit (FU) fed by the issue-stage FU FIFOs.
- Generates the per-FU fu_ready handshake that pops those FIFOs.
- Arbitrates finished FU results onto CDB_W common-data-bus lanes with a round-robin pointer.
- Sits between the FU array and the complete stage; a squash returns every FU to idle.

Parameters:
- NUM_FU, 8, number of FUs (2**`FU); index order matches the FU enum (ALU_1..BRANCH).
- CDB_W, 3, number of CDB lanes granted per cycle.
- IDX_W, $clog2(NUM_FU), width of an FU index.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  mispredict flush; synchronous, same effect as reset on FU state.
- fu_issue  in  NUM_FU  FU i accepted a packet from its FIFO this cycle.
- fu_done  in  NUM_FU  FU i holds a valid result in its output register.
- cdb_grant  out  NUM_FU  FU i's result is driven on a CDB lane this cycle.
- cdb_valid  out  CDB_W  lane k carries a result.
- cdb_idx  out  CDB_W*IDX_W  FU index driving lane k.
- fu_ready  out  NUM_FU  FU i can accept a new packet (rd_EN of the FU FIFO).
- proto_err  out  1  sticky flag: protocol violation seen.

Behaviour:
- Per-FU state, 2 bits each:
  - IDLE: no packet in flight.
  - BUSY: executing.
  - DONE: result is waiting for a CDB lane.
- Request: req[i] = fu_done[i] & (state[i] != IDLE).
  - fu_done while IDLE is ignored and sets proto_err.
- Grant selection (combinational, zero latency):
  - Scan indices rr_ptr, rr_ptr+1, … (mod NUM_FU).
  - The first CDB_W requesters found get grants.
  - Lane 0 takes the first one found; lanes are filled in scan order.
  - Unused lanes: cdb_valid=0, cdb_idx=0.
- rr_ptr update:
  - If any grant this cycle: rr_ptr <= (index of the last granted FU + 1) mod NUM_FU.
  - Otherwise rr_ptr holds.
- fu_ready[i] = (state[i]==IDLE) | cdb_grant[i]. A granted FU may take a new packet in the same cycle, so back-to-back throughput is 1 per cycle per FU.
- Next state for FU i:
  - IDLE, fu_issue → BUSY.
  - BUSY/DONE, granted and fu_issue → BUSY.
  - BUSY/DONE, granted and no fu_issue → IDLE.
  - BUSY, req and not granted → DONE.
  - BUSY, no req → BUSY.
  - DONE, not granted → DONE. The FU must hold its result and keep fu_done high.
- Protocol error: fu_issue while fu_ready[i]=0. The issue is ignored (state unchanged) and proto_err is set.
- squash:
  - Next cycle, all states are IDLE.
  - During the squash cycle, cdb_grant, cdb_valid and cdb_idx are forced to 0.
  - fu_ready is forced to 0 during the squash cycle.
  - rr_ptr holds; proto_err holds.
- reset:
  - All states IDLE, rr_ptr=0, proto_err=0.
  - In the reset cycle all outputs are 0, including fu_ready.
  - From the first cycle after reset: fu_ready = all ones, cdb_* = 0.
- Reset or squash in the same cycle as issue/done: reset/squash wins and the issue is dropped.
- Wrap-around: the scan crosses index NUM_FU-1 → 0 seamlessly. If more than CDB_W requesters exist, the excess FUs stay DONE.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output perf_denied (32 bits): the count of cycles with at least one req not granted.
  - Adds output perf_grants (32 bits): total grants.
  - Both saturate at all ones and clear on reset only, not on squash.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset, then idle → fu_ready=8'hFF, cdb_valid=3'b000, proto_err=0, rr_ptr=0.
- Issue FUs 0,1,2,3 in cycle 1; fu_done on all four in cycle 2:
  - Grants go to FUs 0,1,2 (lanes 0,1,2, cdb_idx={0,1,2}).
  - FU3 goes to DONE with fu_ready[3]=0.
  - Cycle 3: FU3 is granted on lane 0; rr_ptr=4.
- rr_ptr=6 with FUs 7, 0, 1, 5 requesting → lanes get idx 7, 0, 1; FU5 waits; next rr_ptr=2.
- FU2 granted while fu_issue[2]=1 in the same cycle → fu_ready[2]=1 that cycle, state BUSY next cycle, no proto_err.
- squash while FUs 1 and 4 are DONE → that cycle cdb_valid=0 and fu_ready=0; next cycle all IDLE and fu_ready=8'hFF.
- fu_issue[5] while FU5 is BUSY → issue ignored, proto_err=1 and stays 1. With ARB_PERF_CNT_EN: after the scenario-2 cycle, perf_denied=1 and perf_grants=3.
